module_spi_master_ctrl: RTL and testbench

SPI master sequencer (mode 0: CPOL=0, CPHA=0) that runs one 8-bit full-duplex transfer per request. It drives `sclk_o`, `cs_o` and `mosi_o` to the pins, and emits the one-cycle sample strobe `clk_fn_o`. That strobe feeds the shift-enable input of the downstream MISO receive shift register, which holds the received byte once `done_o` pulses. It sits between the peripheral bus register interface (`data_i`/`start_i`) and the SPI pins.

---
 rtl/module_spi_master_ctrl_pkg.sv | 25 ++
 rtl/module_spi_master_ctrl_if.sv | 57 +++++
 rtl/module_spi_master_ctrl_clk_div.sv | 42 ++++
 rtl/module_spi_master_ctrl.sv | 132 +++++++++++++
 tb/tb_module_spi_master_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/module_spi_master_ctrl_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI master sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package spi_pkg;

    // Sequencer states; each non-IDLE state lasts one SCLK half-period
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TAIL  = 3'd4
    } spi_state_t;

    localparam int SPI_BITS         = 8;
    localparam int SPI_DIV_HALF_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/module_spi_master_ctrl_if.sv
// ============================================================================
//  Module      : module_spi_master_ctrl_if
//  Description : Bus-side request/status and SPI pin bundle of the sequencer.
//                Optional cs_hold_i exists only when SPI_CS_HOLD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface module_spi_master_ctrl_if;
    import spi_pkg::*;

    logic                start_i;
    logic [SPI_BITS-1:0] data_i;
`ifdef SPI_CS_HOLD_EN
    logic                cs_hold_i;
`endif
    logic                busy_o;
    logic                done_o;
    logic                clk_fn_o;
    logic                sclk_o;
    logic                cs_o;
    logic                mosi_o;

    // Sequencer side: takes requests, drives pins and status
    modport master (
        input  start_i,
        input  data_i,
`ifdef SPI_CS_HOLD_EN
        input  cs_hold_i,
`endif
        output busy_o,
        output done_o,
        output clk_fn_o,
        output sclk_o,
        output cs_o,
        output mosi_o
    );

    // Requester side: issues transfers and observes status/pins
    modport slave (
        output start_i,
        output data_i,
`ifdef SPI_CS_HOLD_EN
        output cs_hold_i,
`endif
        input  busy_o,
        input  done_o,
        input  clk_fn_o,
        input  sclk_o,
        input  cs_o,
        input  mosi_o
    );

endinterface

`default_nettype wire

// File: rtl/module_spi_master_ctrl_clk_div.sv
// ============================================================================
//  Module      : module_spi_clk_div
//  Description : SCLK half-period counter. Held at zero while i_restart is
//                high; o_tick marks the last cycle of each half-period and
//                the counter wraps to zero on it.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module module_spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV_HALF = SPI_DIV_HALF_DEF
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic i_restart,
    output logic      o_tick
);

    localparam int             c_W    = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [c_W-1:0] c_TERM = c_W'(DIV_HALF - 1);

    logic [c_W-1:0] r_cnt;

    // Count cycles within the current half-period, wrapping at terminal count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == c_TERM)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_restart && (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/module_spi_master_ctrl.sv
// ============================================================================
//  Module      : module_spi_master_ctrl
//  Description : SPI mode-0 master sequencer, one 8-bit transfer per request.
//                Drives SCLK/CS/MOSI and a one-cycle sample strobe at the
//                start of each SCLK high phase for the MISO shift register.
//                Optional macro SPI_CS_HOLD_EN: keep CS low across transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module module_spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_HALF = SPI_DIV_HALF_DEF
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    module_spi_master_ctrl_if.master  bus
);

    localparam logic [2:0] c_LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_t r_state;
    logic [6:0] r_shift;     // bits still to be presented on MOSI
    logic [2:0] r_bitcnt;    // index of the bit in the current HIGH phase
    logic       r_hold;
    logic       r_busy;
    logic       r_done;
    logic       r_clk_fn;
    logic       r_sclk;
    logic       r_cs;
    logic       r_mosi;
    logic       w_tick;
    logic       w_restart;
    logic       w_hold_in;

`ifdef SPI_CS_HOLD_EN
    assign w_hold_in = bus.cs_hold_i;
`else
    assign w_hold_in = 1'b0;
`endif

    // Counter stays at zero while idle so SETUP gets a full half-period
    assign w_restart = (r_state == IDLE);

    module_spi_clk_div #(
        .DIV_HALF (DIV_HALF)
    ) u_clk_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Sequencer FSM with all pin/status outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_hold   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_clk_fn <= 1'b0;
            r_sclk   <= 1'b0;
            r_cs     <= 1'b1;
            r_mosi   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_clk_fn <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state  <= SETUP;
                        r_mosi   <= bus.data_i[7];
                        r_shift  <= bus.data_i[6:0];
                        r_hold   <= w_hold_in;
                        // first HIGH entry wraps this to bit index 0
                        r_bitcnt <= c_LAST_BIT;
                        r_busy   <= 1'b1;
                        r_cs     <= 1'b0;
                        r_sclk   <= 1'b0;
                    end
                end
                SETUP, LOW: begin
                    if (w_tick) begin
                        r_state  <= HIGH;
                        r_sclk   <= 1'b1;
                        r_clk_fn <= 1'b1;
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (w_tick) begin
                        r_sclk <= 1'b0;
                        if (r_bitcnt == c_LAST_BIT) begin
                            r_state <= TAIL;
                        end else begin
                            // MOSI changes only on the falling SCLK edge
                            r_state <= LOW;
                            r_mosi  <= r_shift[6];
                            r_shift <= {r_shift[5:0], 1'b0};
                        end
                    end
                end
                TAIL: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_cs    <= r_hold ? 1'b0 : 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = r_busy;
    assign bus.done_o   = r_done;
    assign bus.clk_fn_o = r_clk_fn;
    assign bus.sclk_o   = r_sclk;
    assign bus.cs_o     = r_cs;
    assign bus.mosi_o   = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_module_spi_master_ctrl.sv
// ============================================================================
//  Module      : tb_module_spi_master_ctrl
//  Description : Directed self-checking bench for module_spi_master_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_module_spi_master_ctrl;
    import spi_pkg::*;

    localparam int DIV_HALF = 4;
    localparam int DONE_CYC = 1 + 17 * DIV_HALF;   // 69

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] r_rx = 8'h00;                      // downstream MISO register

    module_spi_master_ctrl_if ifc ();

    module_spi_master_ctrl #(
        .DIV_HALF (DIV_HALF)
    ) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ifc.master)
    );

    always #5 clk_i = ~clk_i;

    // Receive register looped back from MOSI, shifted on the sample strobe
    always @(posedge clk_i) begin
        if (ifc.clk_fn_o) r_rx <= {r_rx[6:0], ifc.mosi_o};
    end

    // Starts a transfer in the current cycle (caller is at a negedge),
    // collects MOSI at each strobe, returns at the negedge of the done cycle.
    task automatic run_xfer(input logic [7:0] d, output logic [7:0] bits,
                            output int nfn, output int done_cyc);
        bits = '0; nfn = 0; done_cyc = -1;
        ifc.start_i = 1'b1; ifc.data_i = d;
        @(negedge clk_i);
        ifc.start_i = 1'b0; ifc.data_i = ~d;
        for (int n = 1; n <= 100; n++) begin
            if (ifc.clk_fn_o) begin bits = {bits[6:0], ifc.mosi_o}; nfn++; end
            if (ifc.done_o) begin done_cyc = n; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++; if (ifc.cs_o !== 1'b1)     begin n_errors++; $display("FAIL reset_cs got=%b exp=1", ifc.cs_o); end
        n_checks++; if (ifc.sclk_o !== 1'b0)   begin n_errors++; $display("FAIL reset_sclk got=%b exp=0", ifc.sclk_o); end
        n_checks++; if (ifc.busy_o !== 1'b0)   begin n_errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy_o); end
        n_checks++; if (ifc.done_o !== 1'b0)   begin n_errors++; $display("FAIL reset_done got=%b exp=0", ifc.done_o); end
        n_checks++; if (ifc.clk_fn_o !== 1'b0) begin n_errors++; $display("FAIL reset_clk_fn got=%b exp=0", ifc.clk_fn_o); end
        n_checks++; if (ifc.mosi_o !== 1'b0)   begin n_errors++; $display("FAIL reset_mosi got=%b exp=0", ifc.mosi_o); end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    // Cycle-exact check of a 0xA5 transfer against the documented timeline
    task automatic test_basic();
        logic [7:0] pat;
        logic exp_sclk, exp_fn, exp_cs, exp_busy, exp_done, exp_mosi, chk_mosi;
        pat = 8'hA5;
        ifc.start_i = 1'b1; ifc.data_i = pat;
        @(negedge clk_i);
        ifc.start_i = 1'b0; ifc.data_i = 8'h00;
        for (int n = 1; n <= DONE_CYC + 2; n++) begin
            exp_sclk = 1'b0; exp_fn = 1'b0; exp_mosi = 1'b0; chk_mosi = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                if (n >= 1 + (2*k-1)*DIV_HALF && n < 1 + 2*k*DIV_HALF) begin
                    exp_sclk = 1'b1; chk_mosi = 1'b1; exp_mosi = pat[8-k];
                end
                if (n == 1 + (2*k-1)*DIV_HALF) exp_fn = 1'b1;
            end
            exp_cs   = !(n < DONE_CYC);
            exp_busy = (n < DONE_CYC);
            exp_done = (n == DONE_CYC);
            n_checks++; if (ifc.sclk_o !== exp_sclk)  begin n_errors++; $display("FAIL basic_sclk cyc=%0d got=%b exp=%b", n, ifc.sclk_o, exp_sclk); end
            n_checks++; if (ifc.clk_fn_o !== exp_fn)  begin n_errors++; $display("FAIL basic_clk_fn cyc=%0d got=%b exp=%b", n, ifc.clk_fn_o, exp_fn); end
            n_checks++; if (ifc.cs_o !== exp_cs)      begin n_errors++; $display("FAIL basic_cs cyc=%0d got=%b exp=%b", n, ifc.cs_o, exp_cs); end
            n_checks++; if (ifc.busy_o !== exp_busy)  begin n_errors++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", n, ifc.busy_o, exp_busy); end
            n_checks++; if (ifc.done_o !== exp_done)  begin n_errors++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", n, ifc.done_o, exp_done); end
            if (chk_mosi) begin
                n_checks++; if (ifc.mosi_o !== exp_mosi) begin n_errors++; $display("FAIL basic_mosi cyc=%0d got=%b exp=%b", n, ifc.mosi_o, exp_mosi); end
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bits; int nfn, dc;
        run_xfer(8'h3C, bits, nfn, dc);
        n_checks++; if (dc !== DONE_CYC)    begin n_errors++; $display("FAIL loop_done_cycle got=%0d exp=%0d", dc, DONE_CYC); end
        n_checks++; if (nfn !== 8)          begin n_errors++; $display("FAIL loop_strobes got=%0d exp=8", nfn); end
        n_checks++; if (r_rx !== 8'h3C)     begin n_errors++; $display("FAIL loop_rx got=%h exp=3c", r_rx); end
        n_checks++; if (ifc.busy_o !== 1'b0) begin n_errors++; $display("FAIL loop_busy_at_done got=%b exp=0", ifc.busy_o); end
        n_checks++; if (ifc.cs_o !== 1'b1)  begin n_errors++; $display("FAIL loop_cs_at_done got=%b exp=1", ifc.cs_o); end
    endtask

    // Entered at the negedge of the previous transfer's done cycle
    task automatic test_back_to_back();
        logic [7:0] bits; int nfn, dc;
        bits = '0; nfn = 0; dc = -1;
        ifc.start_i = 1'b1; ifc.data_i = 8'hFF;
        @(negedge clk_i);
        ifc.start_i = 1'b0; ifc.data_i = 8'h00;
        n_checks++; if (ifc.cs_o !== 1'b0)   begin n_errors++; $display("FAIL b2b_cs_low got=%b exp=0", ifc.cs_o); end
        n_checks++; if (ifc.busy_o !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got=%b exp=1", ifc.busy_o); end
        for (int n = 1; n <= 100; n++) begin
            if (ifc.clk_fn_o) begin bits = {bits[6:0], ifc.mosi_o}; nfn++; end
            if (ifc.done_o) begin dc = n; break; end
            @(negedge clk_i);
        end
        n_checks++; if (dc !== DONE_CYC) begin n_errors++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", dc, DONE_CYC); end
        n_checks++; if (bits !== 8'hFF)  begin n_errors++; $display("FAIL b2b_bits got=%h exp=ff", bits); end
        n_checks++; if (r_rx !== 8'hFF)  begin n_errors++; $display("FAIL b2b_rx got=%h exp=ff", r_rx); end
        @(negedge clk_i);
    endtask

    task automatic test_ignore_start();
        logic [7:0] bits; int nfn, ndone;
        bits = '0; nfn = 0; ndone = 0;
        ifc.start_i = 1'b1; ifc.data_i = 8'h81;
        @(negedge clk_i);
        for (int n = 1; n <= 150; n++) begin
            ifc.start_i = (n >= 20 && n <= 22);
            ifc.data_i  = 8'h00;
            if (ifc.clk_fn_o) begin bits = {bits[6:0], ifc.mosi_o}; nfn++; end
            if (ifc.done_o) ndone++;
            @(negedge clk_i);
        end
        ifc.start_i = 1'b0;
        n_checks++; if (ndone !== 1)      begin n_errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        n_checks++; if (bits !== 8'h81)   begin n_errors++; $display("FAIL ignore_bits got=%h exp=81", bits); end
        n_checks++; if (nfn !== 8)        begin n_errors++; $display("FAIL ignore_strobes got=%0d exp=8", nfn); end
        n_checks++; if (r_rx !== 8'h81)   begin n_errors++; $display("FAIL ignore_rx got=%h exp=81", r_rx); end
    endtask

    task automatic test_async_reset();
        logic [7:0] bits; int nfn, dc, ndone;
        ifc.start_i = 1'b1; ifc.data_i = 8'h5A;
        @(negedge clk_i);
        ifc.start_i = 1'b0;
        repeat (29) @(negedge clk_i);          // now in cycle 30: SCLK high, MOSI=1
        n_checks++; if (ifc.sclk_o !== 1'b1) begin n_errors++; $display("FAIL arst_pre_sclk got=%b exp=1", ifc.sclk_o); end
        #2 rst_i = 1'b1;
        #1;
        n_checks++; if (ifc.cs_o !== 1'b1)     begin n_errors++; $display("FAIL arst_cs got=%b exp=1", ifc.cs_o); end
        n_checks++; if (ifc.sclk_o !== 1'b0)   begin n_errors++; $display("FAIL arst_sclk got=%b exp=0", ifc.sclk_o); end
        n_checks++; if (ifc.busy_o !== 1'b0)   begin n_errors++; $display("FAIL arst_busy got=%b exp=0", ifc.busy_o); end
        n_checks++; if (ifc.mosi_o !== 1'b0)   begin n_errors++; $display("FAIL arst_mosi got=%b exp=0", ifc.mosi_o); end
        n_checks++; if (ifc.clk_fn_o !== 1'b0) begin n_errors++; $display("FAIL arst_clk_fn got=%b exp=0", ifc.clk_fn_o); end
        n_checks++; if (ifc.done_o !== 1'b0)   begin n_errors++; $display("FAIL arst_done got=%b exp=0", ifc.done_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        ndone = 0;
        for (int n = 0; n < 100; n++) begin
            if (ifc.done_o) ndone++;
            @(negedge clk_i);
        end
        n_checks++; if (ndone !== 0) begin n_errors++; $display("FAIL arst_no_done got=%0d exp=0", ndone); end
        run_xfer(8'hC3, bits, nfn, dc);
        n_checks++; if (dc !== DONE_CYC) begin n_errors++; $display("FAIL arst_next_done got=%0d exp=%0d", dc, DONE_CYC); end
        n_checks++; if (bits !== 8'hC3)  begin n_errors++; $display("FAIL arst_next_bits got=%h exp=c3", bits); end
        @(negedge clk_i);
    endtask

`ifdef SPI_CS_HOLD_EN
    task automatic test_cs_hold();
        logic [7:0] bits; int nfn, dc;
        ifc.cs_hold_i = 1'b1;
        run_xfer(8'h12, bits, nfn, dc);
        ifc.cs_hold_i = 1'b0;
        n_checks++; if (dc !== DONE_CYC)     begin n_errors++; $display("FAIL hold_first_done got=%0d exp=%0d", dc, DONE_CYC); end
        n_checks++; if (bits !== 8'h12)      begin n_errors++; $display("FAIL hold_first_bits got=%h exp=12", bits); end
        n_checks++; if (ifc.busy_o !== 1'b0) begin n_errors++; $display("FAIL hold_busy_at_done got=%b exp=0", ifc.busy_o); end
        for (int n = 0; n < 3; n++) begin
            n_checks++; if (ifc.cs_o !== 1'b0) begin n_errors++; $display("FAIL hold_cs_idle n=%0d got=%b exp=0", n, ifc.cs_o); end
            @(negedge clk_i);
        end
        bits = '0; dc = -1;
        ifc.start_i = 1'b1; ifc.data_i = 8'h34;
        @(negedge clk_i);
        ifc.start_i = 1'b0; ifc.data_i = 8'h00;
        for (int n = 1; n <= 100; n++) begin
            if (ifc.clk_fn_o) bits = {bits[6:0], ifc.mosi_o};
            if (ifc.done_o) begin dc = n; break; end
            n_checks++; if (ifc.cs_o !== 1'b0) begin n_errors++; $display("FAIL hold_cs_second cyc=%0d got=%b exp=0", n, ifc.cs_o); end
            @(negedge clk_i);
        end
        n_checks++; if (dc !== DONE_CYC)   begin n_errors++; $display("FAIL hold_second_done got=%0d exp=%0d", dc, DONE_CYC); end
        n_checks++; if (ifc.cs_o !== 1'b1) begin n_errors++; $display("FAIL hold_cs_release got=%b exp=1", ifc.cs_o); end
        n_checks++; if (bits !== 8'h34)    begin n_errors++; $display("FAIL hold_second_bits got=%h exp=34", bits); end
        @(negedge clk_i);
    endtask
`endif

    initial begin
        ifc.start_i = 1'b0;
        ifc.data_i  = 8'h00;
`ifdef SPI_CS_HOLD_EN
        ifc.cs_hold_i = 1'b0;
`endif
        test_reset();
        test_basic();
        test_loopback();
        test_back_to_back();
        test_ignore_start();
        test_async_reset();
`ifdef SPI_CS_HOLD_EN
        test_cs_hold();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
